// File: rtl/zv_pkg.sv
// Shared zv line-compression definitions: line geometry, rank width and
// mapping-table entry width derivation.
package zv_pkg;

    localparam int LINE_SIZE  = 128;
    localparam int RANK_WIDTH = 8;
    localparam int SLOT_WIDTH = $clog2(LINE_SIZE);

    typedef logic [RANK_WIDTH-1:0] rank_t;

    function automatic int entry_width(input int dist_width, input int max_rsiz);
        return dist_width * max_rsiz;
    endfunction

endpackage

// File: rtl/zv_rank_gen128.sv
// Exclusive prefix count of live (mask == 0) positions across a 128-entry line.
// Also returns the total live count used for the sender-count cross-check.
module zv_rank_gen128
    import zv_pkg::*;
(
    input  logic [LINE_SIZE-1:0]  mask,
    output rank_t [LINE_SIZE-1:0] rank,
    output rank_t                 live_count
);

    rank_t acc;

    always_comb begin
        // NOTE: every variable written here gets a value before any branch or
        // loop reads it, so no storage (latch) can be inferred.
        acc  = '0;
        rank = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            rank[i] = acc;
            acc     = acc + {{(RANK_WIDTH-1){1'b0}}, ~mask[i]};
        end
        live_count = acc;
    end

endmodule

// File: rtl/zv_decompressor128.sv
// Two-stage elastic decompressor: re-inserts zero bubbles into a packed
// LIFM line and its mapping table using the per-position live rank.
module zv_decompressor128
    import zv_pkg::*;
#(
    parameter  int WORD_WIDTH    = 8,
    parameter  int DIST_WIDTH    = 7,
    parameter  int MAX_LIFM_RSIZ = 4,
    localparam int ENTRY_WIDTH   = entry_width(DIST_WIDTH, MAX_LIFM_RSIZ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]  lifm_comp,
    input  logic [LINE_SIZE*ENTRY_WIDTH-1:0] mt_comp,
    input  logic [LINE_SIZE-1:0]             mask,
    input  logic [RANK_WIDTH-1:0]            in_count,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]  lifm_line,
    output logic [LINE_SIZE*ENTRY_WIDTH-1:0] mt_line,
    output logic                             out_err
);

    typedef logic [LINE_SIZE-1:0][WORD_WIDTH-1:0]  lifm_vec_t;
    typedef logic [LINE_SIZE-1:0][ENTRY_WIDTH-1:0] mt_vec_t;

    rank_t [LINE_SIZE-1:0] rank_in;
    rank_t                 live_count;

    zv_rank_gen128 u_rank_gen (
        .mask       (mask),
        .rank       (rank_in),
        .live_count (live_count)
    );

    logic                  s1_valid;
    lifm_vec_t             s1_lifm;
    mt_vec_t               s1_mt;
    logic [LINE_SIZE-1:0]  s1_mask;
    rank_t [LINE_SIZE-1:0] s1_rank;
    logic                  s1_err;

    logic                  s2_valid;
    lifm_vec_t             s2_lifm;
    mt_vec_t               s2_mt;
    logic                  s2_err;

    lifm_vec_t             exp_lifm;
    mt_vec_t               exp_mt;

    logic s2_advance;
    logic s1_advance;
    logic in_accept;

    // Backpressure ripples combinationally from out_ready back to in_ready.
    assign s2_advance = !s2_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;
    assign in_accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the wide data registers are cleared as well, so the output
            // bus is all zero rather than stale after a reset.
            s1_valid <= 1'b0;
            s1_lifm  <= '0;
            s1_mt    <= '0;
            s1_mask  <= '0;
            s1_rank  <= '0;
            s1_err   <= 1'b0;
        end else begin
            if (s1_advance) begin
                s1_valid <= in_valid;
            end
            if (in_accept) begin
                s1_lifm <= lifm_comp;
                s1_mt   <= mt_comp;
                s1_mask <= mask;
                s1_rank <= rank_in;
                s1_err  <= (live_count != in_count);
            end
        end
    end

    // A live position's rank is always below LINE_SIZE; the range guard keeps
    // the full rank word meaningful and yields a bubble otherwise.
    always_comb begin
        exp_lifm = '0;
        exp_mt   = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (!s1_mask[i] && (s1_rank[i] < rank_t'(LINE_SIZE))) begin
                exp_lifm[i] = s1_lifm[s1_rank[i][SLOT_WIDTH-1:0]];
                exp_mt[i]   = s1_mt[s1_rank[i][SLOT_WIDTH-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_lifm  <= '0;
            s2_mt    <= '0;
            s2_err   <= 1'b0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_lifm <= exp_lifm;
                s2_mt   <= exp_mt;
                s2_err  <= s1_err;
            end
        end
    end

    assign out_valid = s2_valid;
    assign lifm_line = s2_lifm;
    assign mt_line   = s2_mt;
    assign out_err   = s2_err;

endmodule

// File: doc/zv_decompressor128.md
ZV_DECOMPRESSOR128 -- requirements
Module: zv_decompressor128

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, LIFM word width in bits.
REQ-002 SHALL have parameter DIST_WIDTH, default 7, mapping-table distance field width in bits.
REQ-003 SHALL have parameter MAX_LIFM_RSIZ, default 4, distance fields per mapping-table entry; ENTRY_WIDTH = DIST_WIDTH*MAX_LIFM_RSIZ.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  compressed line present.
REQ-007 SHALL have port in_ready  output  1  block accepts a line this cycle.
REQ-008 SHALL have port lifm_comp  input  128*WORD_WIDTH  packed nonzero LIFM words, slot 0 at LSBs.
REQ-009 SHALL have port mt_comp  input  128*ENTRY_WIDTH  packed mapping-table entries, same slot order.
REQ-010 SHALL have port mask  input  128  bit i = 1: position i is a bubble (zero entry).
REQ-011 SHALL have port in_count  input  8  number of valid packed slots claimed by the sender (0..128).
REQ-012 SHALL have port out_valid  output  1  expanded line present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the line this cycle.
REQ-014 SHALL have port lifm_line  output  128*WORD_WIDTH  expanded LIFM line.
REQ-015 SHALL have port mt_line  output  128*ENTRY_WIDTH  expanded mapping table.
REQ-016 SHALL have port out_err  output  1  popcount(~mask) != in_count for this line.

Function
REQ-017 SHALL transfer a line on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-018 SHALL be a two-stage elastic pipeline: stage 1 registers inputs plus rank vector; stage 2 registers expanded result.
REQ-019 SHALL compute rank[i] = number of j < i with mask[j] == 0 (exclusive prefix count), 8 bits per position, combinationally before stage 1 register.
REQ-020 SHALL drive, for mask[i] == 0, lifm_line word i = lifm_comp slot rank[i] and mt_line entry i = mt_comp slot rank[i].
REQ-021 SHALL drive, for mask[i] == 1, lifm_line word i = 0 and mt_line entry i = 0.
REQ-022 SHALL ignore packed slots at or above popcount(~mask); their contents never reach the output.
REQ-023 SHALL present out_err with the same line it describes; data is still expanded per REQ-020/021 when out_err = 1.
REQ-024 SHALL have latency exactly 2 cycles from input transfer to out_valid with out_ready held high.
REQ-025 SHALL sustain one line per cycle with out_ready held high.
REQ-026 SHALL advance stage 2 when stage 2 empty or out_ready = 1; stage 1 advances when stage 1 empty or stage 2 advances.
REQ-027 SHALL assert in_ready = !stage1_valid || stage2 advancing; combinational path from out_ready to in_ready permitted.
REQ-028 SHALL hold lifm_line, mt_line, out_err stable while out_valid && !out_ready.
REQ-029 SHALL accept simultaneous input and output transfers in the same cycle without loss or duplication.
REQ-030 SHALL handle mask = all ones (output all zero) and mask = all zeros (output = packed input unchanged).

Reset
REQ-031 SHALL, while reset = 1 at a clock edge, clear both stage valid flags, all data registers, out_err; out_valid = 0.
REQ-032 SHALL drive in_ready = 1 from the first cycle after reset deasserts.
REQ-033 SHALL discard any in-flight lines on reset asserted mid-operation; no partial line emitted afterwards.

Structure
REQ-034 SHALL place LINE_SIZE = 128, RANK_WIDTH = 8, and ENTRY_WIDTH derivation in the shared zv package used by the compressor.
REQ-035 SHALL implement the rank computation in one sub-module, zv_rank_gen128 (mask in, 128x8 exclusive counts out, purely combinational).

Verification
REQ-036 SHALL cover: mask = 128'h...FFFE (only bit 0 clear), lifm_comp slot0 = 8'hA5, in_count = 1 -> lifm_line word0 = 8'hA5, all else 0, out_err = 0, out_valid 2 cycles after accept.
REQ-037 SHALL cover: mask bits 1,3 set, rest clear, packed slots k = k+1 -> word0 = 1, word1 = 0, word2 = 2, word3 = 0, word4 = 3, word127 = 126.
REQ-038 SHALL cover: 10 back-to-back lines, out_ready = 1 -> 10 outputs in order on consecutive cycles, in_ready never low.
REQ-039 SHALL cover: out_ready = 0 for 5 cycles with 3 lines offered -> 2 lines buffered, in_ready = 0 on third, outputs stable, all 3 delivered in order after release.
REQ-040 SHALL cover: mask = 0, in_count = 100 -> expanded line equals packed input, out_err = 1.
REQ-041 SHALL cover: reset asserted with 2 lines in flight -> out_valid = 0 next cycle, neither line ever emitted; round-trip compressor->decompressor on random lines reproduces original with zero entries.
